// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg
// Shared types and helpers for the FIFO write arbiter and its round-robin picker.
//   arb_st_t    : arbiter FSM state encoding
//   clog2_min1  : ceil(log2(n)), never less than 1, for sizing index/counter fields
package fifo_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_st_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick
// Combinational round-robin selector. The search starts at last_i+1 (mod REQ_N)
// and moves upward, so the most recent owner has the lowest priority.
// Ports:
//   req_i   in  REQ_N  request vector
//   last_i  in  ID_W   index of the previous owner
//   win_o   out ID_W   selected index (meaningful only when vld_o=1)
//   vld_o   out 1      at least one request present
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter  int REQ_N = 4,
    localparam int ID_W  = clog2_min1(REQ_N)
) (
    input  logic [REQ_N-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic [ID_W-1:0]  win_o,
    output logic             vld_o
);

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int step);
        return ID_W'((int'(base) + step) % REQ_N);
    endfunction

    logic [REQ_N-1:0] rot;
    logic [ID_W-1:0]  off;

    // rot[0] is the requester right after last_i; the lowest set bit of rot
    // is the winner's distance from last_i+1.
    always_comb begin
        rot = '0;
        for (int j = 0; j < REQ_N; j++) begin
            rot[j] = req_i[wrap_idx(last_i, j + 1)];
        end
        off = '0;
        for (int j = REQ_N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = ID_W'(j);
            end
        end
        vld_o = |req_i;
        win_o = wrap_idx(last_i, int'(off) + 1);
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
// Round-robin write arbiter: REQ_N valid/ready producers share one fifo_buf
// write port. The owner keeps the port for up to BURST_MAX words (0 = until it
// drops req), then one IDLE cycle is spent re-arbitrating.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_i/req_data_i   per-requester valid and packed payloads
//   req_rdy_o          per-requester ready
//   fifo_data_o/id_o   payload and owner index toward fifo wr_data_i
//   fifo_wr_o          fifo write strobe; fifo_wr_rdy_i is the fifo's ready
//   grant_o/busy_o     one-hot owner, and GRANT-state flag
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter  int REQ_N     = 4,
    parameter  int DATA_W    = 8,
    parameter  int BURST_MAX = 4,
    localparam int ID_W      = clog2_min1(REQ_N)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [REQ_N-1:0]         req_i,
    input  logic [REQ_N*DATA_W-1:0]  req_data_i,
    output logic [REQ_N-1:0]         req_rdy_o,
    output logic [DATA_W-1:0]        fifo_data_o,
    output logic [ID_W-1:0]          fifo_id_o,
    output logic                     fifo_wr_o,
    input  logic                     fifo_wr_rdy_i,
    output logic [REQ_N-1:0]         grant_o,
    output logic                     busy_o
);

    localparam int CNT_W = clog2_min1(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (BURST_MAX > 0) ? CNT_W'(BURST_MAX - 1) : '0;

    arb_st_t           state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ID_W-1:0]   pick_win;
    logic              pick_vld;
    logic [REQ_N-1:0]  owner_oh;
    logic              in_grant;
    logic              owner_req;
    logic              xfer;
    logic [DATA_W-1:0] data_arr [REQ_N];

    rr_pick #(.REQ_N(REQ_N)) u_pick (
        .req_i  (req_i),
        .last_i (last_q),
        .win_o  (pick_win),
        .vld_o  (pick_vld)
    );

    always_comb begin
        for (int k = 0; k < REQ_N; k++) begin
            data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
        end
    end

    assign in_grant  = (state_q == ST_GRANT);
    assign owner_oh  = REQ_N'(1) << owner_q;
    assign owner_req = req_i[owner_q];
    // rst_i gates the handshake so a word is never consumed in a reset cycle.
    assign xfer      = in_grant & owner_req & fifo_wr_rdy_i & ~rst_i;

    assign fifo_wr_o   = xfer;
    assign req_rdy_o   = (in_grant && fifo_wr_rdy_i && !rst_i) ? owner_oh : '0;
    assign grant_o     = in_grant ? owner_oh : '0;
    assign busy_o      = in_grant;
    assign fifo_data_o = data_arr[owner_q];
    assign fifo_id_o   = owner_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    owner_d = pick_win;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                // A dropped request releases even while the fifo is stalled.
                if (!owner_req) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else if (xfer && (BURST_MAX > 0)) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        last_d  = owner_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= ID_W'(REQ_N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;
    localparam int REQ_N  = 4;
    localparam int DATA_W = 8;
    localparam int BM     = 4;
    localparam int ID_W   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_i    = 1'b1;
    logic [REQ_N-1:0]        req      = '0;
    logic [REQ_N*DATA_W-1:0] req_data = '0;
    logic                    fifo_rdy = 1'b1;
    logic [REQ_N-1:0]        req_rdy, grant;
    logic [DATA_W-1:0]       f_data;
    logic [ID_W-1:0]         f_id;
    logic                    f_wr, busy;

    logic [REQ_N-1:0]        req0      = '0;
    logic [REQ_N*DATA_W-1:0] req_data0 = '0;
    logic                    fifo_rdy0 = 1'b1;
    logic [REQ_N-1:0]        req_rdy0, grant0;
    logic [DATA_W-1:0]       f_data0;
    logic [ID_W-1:0]         f_id0;
    logic                    f_wr0, busy0;

    fifo_wr_arb #(.REQ_N(REQ_N), .DATA_W(DATA_W), .BURST_MAX(BM)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req), .req_data_i(req_data),
        .req_rdy_o(req_rdy), .fifo_data_o(f_data), .fifo_id_o(f_id),
        .fifo_wr_o(f_wr), .fifo_wr_rdy_i(fifo_rdy), .grant_o(grant), .busy_o(busy)
    );

    fifo_wr_arb #(.REQ_N(REQ_N), .DATA_W(DATA_W), .BURST_MAX(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req0), .req_data_i(req_data0),
        .req_rdy_o(req_rdy0), .fifo_data_o(f_data0), .fifo_id_o(f_id0),
        .fifo_wr_o(f_wr0), .fifo_wr_rdy_i(fifo_rdy0), .grant_o(grant0), .busy_o(busy0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REQ_N-1:0] onehot(input int k);
        return REQ_N'(1) << k;
    endfunction

    // Round-robin rule: first requester strictly after 'last', wrapping.
    function automatic int rr_next(input logic [REQ_N-1:0] r, input int last);
        for (int i = 1; i <= REQ_N; i++) begin
            if (r[ID_W'((last + i) % REQ_N)]) return (last + i) % REQ_N;
        end
        return -1;
    endfunction

    // ---------------- scoreboard / reference model state ----------------
    logic [7:0]       exp_q [REQ_N][$];
    logic [REQ_N-1:0] xfer_vec = '0;
    int               pend [REQ_N];
    int               seq  [REQ_N];
    int               pres_pct = 100;
    bit               rand_rdy = 0;

    typedef enum {E_NONE, E_POSTRST, E_GRANT, E_HOLD, E_IDLE} exp_t;
    exp_t m_exp   = E_NONE;
    int   m_last  = REQ_N - 1;
    int   m_owner = 0;
    int   m_words = 0;
    int   cyc     = 0;
    int   xfer_cyc [$];

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_i) begin
                chk("rst_wr", f_wr, 0);
                chk("rst_rdy", req_rdy, 0);
                xfer_vec = '0;
                m_last   = REQ_N - 1;
                m_words  = 0;
                m_exp    = E_POSTRST;
            end else begin
                xfer_vec = req & req_rdy;
                case (m_exp)
                    E_POSTRST: begin
                        chk("reset_busy", busy, 0);
                        chk("reset_grant", grant, 0);
                        chk("reset_id", f_id, 0);
                    end
                    E_GRANT: begin
                        chk("arb_busy", busy, 1);
                        chk("arb_grant", grant, onehot(m_owner));
                    end
                    E_HOLD: begin
                        chk("hold_busy", busy, 1);
                        chk("hold_grant", grant, onehot(m_owner));
                    end
                    E_IDLE: chk("release_busy", busy, 0);
                    default: ;
                endcase
                if (m_exp == E_GRANT || m_exp == E_HOLD) begin
                    chk("grant_rdy", req_rdy, fifo_rdy ? onehot(m_owner) : '0);
                    chk("grant_wr", f_wr, req[ID_W'(m_owner)] & fifo_rdy);
                    chk("grant_id", f_id, m_owner);
                    if (f_wr) begin
                        m_words++;
                        xfer_cyc.push_back(cyc);
                        if (exp_q[ID_W'(m_owner)].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_extra id=%0d data=%0h required=none", m_owner, f_data);
                        end else begin
                            chk("sb_data", f_data, exp_q[ID_W'(m_owner)].pop_front());
                        end
                    end
                    if (!req[ID_W'(m_owner)] || (f_wr && m_words == BM)) begin
                        m_exp  = E_IDLE;
                        m_last = m_owner;
                    end else begin
                        m_exp = E_HOLD;
                    end
                end else if (m_exp != E_NONE) begin
                    chk("idle_wr", f_wr, 0);
                    chk("idle_rdy", req_rdy, 0);
                    chk("idle_grant", grant, 0);
                    if (req != '0) begin
                        m_owner = rr_next(req, m_last);
                        m_words = 0;
                        m_exp   = E_GRANT;
                    end else begin
                        m_exp = E_IDLE;
                    end
                end
            end
        end
    end

    // ---------------- producers ----------------
    task automatic step();
        logic [7:0] w;
        @(posedge clk);
        #1;
        for (int k = 0; k < REQ_N; k++) begin
            if (xfer_vec[ID_W'(k)]) begin
                req[ID_W'(k)] = 1'b0;
                pend[k]--;
            end
            if (!req[ID_W'(k)] && pend[k] > 0 && $urandom_range(99) < pres_pct) begin
                w = {ID_W'(k), 6'(seq[k])};
                seq[k]++;
                req_data[5'(k*DATA_W) +: DATA_W] = w;
                exp_q[ID_W'(k)].push_back(w);
                req[ID_W'(k)] = 1'b1;
            end
        end
        if (rand_rdy) fifo_rdy = ($urandom_range(3) != 0);
    endtask

    function automatic int pend_total();
        int s = 0;
        for (int k = 0; k < REQ_N; k++) s += pend[k];
        return s;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((req != '0 || pend_total() > 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, pend_total());
        end
        repeat (2) step();
    endtask

    // ---------------- BURST_MAX=0 instance checker ----------------
    logic [15:0]      exp0_q [$];
    logic [REQ_N-1:0] xfer0_vec = '0;

    initial begin : monitor0
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                xfer0_vec = '0;
            end else begin
                xfer0_vec = req0 & req_rdy0;
                if (f_wr0) begin
                    if (exp0_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b0_extra id=%0d data=%0h required=none", f_id0, f_data0);
                    end else begin
                        e = exp0_q.pop_front();
                        chk("b0_id", f_id0, e[15:8]);
                        chk("b0_data", f_data0, e[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int  start;
        int  offs [6] = '{1, 2, 3, 4, 6, 7};
        int  stall_cnt;
        bit  hit;
        int  sent;
        bit  fin;

        for (int k = 0; k < REQ_N; k++) begin
            pend[k] = 0;
            seq[k]  = 0;
        end
        repeat (3) step();
        rst_i = 1'b0;

        // single requester, 6 words: 4-word burst, one idle cycle, 2 words
        pend[0] = 6;
        step();
        start = cyc + 1;
        xfer_cyc.delete();
        repeat (10) step();
        chk("p1_count", xfer_cyc.size(), 6);
        if (xfer_cyc.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("p1_xfer_cycle", xfer_cyc[i] - start, offs[i]);
        end
        drain("p1", 50);

        // requester 1 drops after 2 words while others request
        pend[1] = 2; pend[0] = 6; pend[2] = 6; pend[3] = 6;
        drain("drop", 200);

        // all continuously requesting, no stall
        for (int k = 0; k < REQ_N; k++) pend[k] = 12;
        drain("cont", 300);

        // fifo stall mid-burst for 3 cycles
        for (int k = 0; k < REQ_N; k++) pend[k] = 8;
        hit = 0;
        stall_cnt = 0;
        for (int i = 0; i < 300 && (req != '0 || pend_total() > 0); i++) begin
            step();
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) fifo_rdy = 1'b1;
            end else if (!hit && m_exp == E_HOLD && m_words == 2) begin
                fifo_rdy  = 1'b0;
                stall_cnt = 3;
                hit       = 1;
            end
        end
        chk("stall_hit", hit, 1);
        drain("stall", 50);

        // reset during the 3rd word of a burst
        for (int k = 0; k < REQ_N; k++) pend[k] = 8;
        hit = 0;
        for (int i = 0; i < 300 && (req != '0 || pend_total() > 0); i++) begin
            step();
            if (rst_i) begin
                rst_i = 1'b0;
            end else if (!hit && m_exp == E_HOLD && m_words == 2) begin
                rst_i = 1'b1;
                hit   = 1;
            end
        end
        chk("rst_hit", hit, 1);
        drain("rst", 50);

        // randomized traffic with random fifo backpressure
        pres_pct = 60;
        rand_rdy = 1;
        for (int k = 0; k < REQ_N; k++) pend[k] = 40;
        repeat (500) step();
        rand_rdy = 0;
        fifo_rdy = 1'b1;
        pres_pct = 100;
        drain("rand", 400);
        for (int k = 0; k < REQ_N; k++) chk("sb_empty", exp_q[ID_W'(k)].size(), 0);

        // BURST_MAX=0: requester 2 streams 20 words, requester 1 waits
        for (int i = 0; i < 20; i++) exp0_q.push_back({8'd2, 8'(8'hC0 + i)});
        exp0_q.push_back({8'd1, 8'h1B});
        req_data0[23:16] = 8'hC0;
        req0[2] = 1'b1;
        sent = 0;
        fin  = 0;
        for (int i = 0; i < 120 && !fin; i++) begin
            @(posedge clk);
            #1;
            if (xfer0_vec[2]) begin
                sent++;
                if (sent < 20) req_data0[23:16] = 8'(8'hC0 + sent);
                else           req0[2] = 1'b0;
                if (sent == 1) begin
                    req_data0[15:8] = 8'h1B;
                    req0[1] = 1'b1;
                end
            end
            if (xfer0_vec[1]) begin
                req0[1] = 1'b0;
                fin = 1;
            end
        end
        chk("b0_done", fin, 1);
        chk("b0_sent", sent, 20);
        repeat (2) @(posedge clk);
        chk("b0_q_empty", exp0_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
